// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline boundary.
// The decode stage imports this package too, so both sides agree on the
// writeback-select encoding and the default datapath width.
package mem_wb_stage_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int REGS_DEFAULT  = 8;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// 4:1 writeback source selector feeding the MEM/WB data register.
module wb_mux
    import mem_wb_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pc_inc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result
);

    // Pick the writeback value according to the encoded source.
    always_comb begin
        result = alu_res;
        case (sel)
            WB_MEM:  result = rdata;
            WB_LINK: result = pc_inc;
            WB_IMM:  result = imm;
            default: result = alu_res;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file write control,
// retirement counter, HALT tracking and a sticky illegal-control flag.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int REGS  = REGS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_valid,
    input  logic                    mem_regwrite,
    input  logic [$clog2(REGS)-1:0] mem_dest,
    input  logic [1:0]              mem_wbsel,
    input  logic [WIDTH-1:0]        mem_alu_res,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic [WIDTH-1:0]        mem_pc_inc,
    input  logic [WIDTH-1:0]        mem_imm,
    input  logic                    mem_halt,
    input  logic                    stall,
    input  logic                    flush,
    output logic [$clog2(REGS)-1:0] target_WB,
    output logic [WIDTH-1:0]        writedata,
    output logic                    write,
    output logic                    wb_valid,
    output logic                    halted,
    output logic [15:0]             retire_cnt,
    output logic                    err
);

    logic             stage_valid;
    logic             stage_regwrite;
    logic             stage_halt;
    logic [WIDTH-1:0] wb_value;
    logic             capture;
    logic             retire;

    // The source is chosen before the register so writedata leaves a flop.
    wb_mux #(
        .WIDTH(WIDTH)
    ) u_wb_mux (
        .sel    (mem_wbsel),
        .alu_res(mem_alu_res),
        .rdata  (mem_rdata),
        .pc_inc (mem_pc_inc),
        .imm    (mem_imm),
        .result (wb_value)
    );

    // A stalled instruction stays put and only leaves when stall drops,
    // which is what keeps it to a single register-file write.
    assign capture  = ~stall & ~flush;
    assign retire   = stage_valid & ~stall & ~halted;
    assign write    = stage_valid & stage_regwrite & ~halted & ~stall;
    assign wb_valid = stage_valid;

    // Stage registers: flush makes a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid    <= 1'b0;
            stage_regwrite <= 1'b0;
            stage_halt     <= 1'b0;
            target_WB      <= '0;
            writedata      <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else if (!stall) begin
            stage_valid    <= mem_valid;
            stage_regwrite <= mem_regwrite;
            stage_halt     <= mem_halt;
            target_WB      <= mem_dest;
            writedata      <= wb_value;
        end
    end

    // Retirement bookkeeping; a retiring HALT still counts, then all freezes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= 16'd0;
            halted     <= 1'b0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 16'd1;
            if (stage_halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Sticky error for contradictory control or a HALT that claims a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((stall & flush) |
                     (capture & mem_valid & mem_halt & mem_regwrite)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_regwrite;
    logic [2:0]  mem_dest;
    logic [1:0]  mem_wbsel;
    logic [15:0] mem_alu_res;
    logic [15:0] mem_rdata;
    logic [15:0] mem_pc_inc;
    logic [15:0] mem_imm;
    logic        mem_halt;
    logic        stall;
    logic        flush;
    logic [2:0]  target_WB;
    logic [15:0] writedata;
    logic        write;
    logic        wb_valid;
    logic        halted;
    logic [15:0] retire_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(
        .WIDTH(16),
        .REGS (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_regwrite(mem_regwrite),
        .mem_dest    (mem_dest),
        .mem_wbsel   (mem_wbsel),
        .mem_alu_res (mem_alu_res),
        .mem_rdata   (mem_rdata),
        .mem_pc_inc  (mem_pc_inc),
        .mem_imm     (mem_imm),
        .mem_halt    (mem_halt),
        .stall       (stall),
        .flush       (flush),
        .target_WB   (target_WB),
        .writedata   (writedata),
        .write       (write),
        .wb_valid    (wb_valid),
        .halted      (halted),
        .retire_cnt  (retire_cnt),
        .err         (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid    = 1'b0;
        mem_regwrite = 1'b0;
        mem_dest     = 3'd0;
        mem_wbsel    = 2'b00;
        mem_alu_res  = 16'h0000;
        mem_rdata    = 16'h0000;
        mem_pc_inc   = 16'h0000;
        mem_imm      = 16'h0000;
        mem_halt     = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_op(input logic v, input logic rw, input logic [2:0] d,
                            input logic [1:0] s, input logic h,
                            input logic [15:0] alu, input logic [15:0] rd,
                            input logic [15:0] pc, input logic [15:0] im);
        mem_valid    = v;
        mem_regwrite = rw;
        mem_dest     = d;
        mem_wbsel    = s;
        mem_halt     = h;
        mem_alu_res  = alu;
        mem_rdata    = rd;
        mem_pc_inc   = pc;
        mem_imm      = im;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write: got %b want 0", write); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        checks++; if (retire_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL reset_retire_cnt: got %h want 0000", retire_cnt); end
        checks++; if (target_WB !== 3'd0) begin failures++; $display("[TB] FAIL reset_target: got %0d want 0", target_WB); end
        checks++; if (writedata !== 16'h0000) begin failures++; $display("[TB] FAIL reset_writedata: got %h want 0000", writedata); end
    endtask

    task automatic test_load_capture();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd3, WB_MEM, 1'b0, 16'h1111, 16'hBEEF, 16'h2222, 16'h3333);
        tick();
        idle_inputs();
        checks++; if (write !== 1'b1) begin failures++; $display("[TB] FAIL load_write: got %b want 1", write); end
        checks++; if (target_WB !== 3'd3) begin failures++; $display("[TB] FAIL load_target: got %0d want 3", target_WB); end
        checks++; if (writedata !== 16'hBEEF) begin failures++; $display("[TB] FAIL load_writedata: got %h want beef", writedata); end
        checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL load_cnt_before: got %0d want 0", retire_cnt); end
        tick();
        checks++; if (retire_cnt !== 16'd1) begin failures++; $display("[TB] FAIL load_cnt_after: got %0d want 1", retire_cnt); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL load_bubble_write: got %b want 0", write); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [4];
        exp_data[0] = 16'h1111;
        exp_data[1] = 16'h2222;
        exp_data[2] = 16'h3333;
        exp_data[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, 1'b1, 3'(i + 1), 2'(i), 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
            tick();
            checks++; if (writedata !== exp_data[i]) begin failures++; $display("[TB] FAIL b2b_data sel=%0d: got %h want %h", i, writedata, exp_data[i]); end
            checks++; if (target_WB !== 3'(i + 1)) begin failures++; $display("[TB] FAIL b2b_target sel=%0d: got %0d want %0d", i, target_WB, i + 1); end
            checks++; if (write !== 1'b1) begin failures++; $display("[TB] FAIL b2b_write sel=%0d: got %b want 1", i, write); end
            checks++; if (retire_cnt !== 16'(i)) begin failures++; $display("[TB] FAIL b2b_cnt sel=%0d: got %0d want %0d", i, retire_cnt, i); end
        end
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== 16'd4) begin failures++; $display("[TB] FAIL b2b_cnt_final: got %0d want 4", retire_cnt); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL b2b_write_final: got %b want 0", write); end
    endtask

    task automatic test_stall();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd5, WB_ALU, 1'b0, 16'h0012, 16'h0000, 16'h0000, 16'h0000);
        tick();
        drive_op(1'b1, 1'b1, 3'd7, WB_ALU, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL stall_write cyc=%0d: got %b want 0", i, write); end
            checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL stall_cnt cyc=%0d: got %0d want 0", i, retire_cnt); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (write !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_write: got %b want 1", write); end
        checks++; if (target_WB !== 3'd5) begin failures++; $display("[TB] FAIL stall_release_target: got %0d want 5", target_WB); end
        checks++; if (writedata !== 16'h0012) begin failures++; $display("[TB] FAIL stall_release_data: got %h want 0012", writedata); end
        tick();
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL stall_after_write: got %b want 0", write); end
        checks++; if (retire_cnt !== 16'd1) begin failures++; $display("[TB] FAIL stall_after_cnt: got %0d want 1", retire_cnt); end
        tick();
        checks++; if (retire_cnt !== 16'd1) begin failures++; $display("[TB] FAIL stall_cnt_stable: got %0d want 1", retire_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd2, WB_ALU, 1'b0, 16'h0055, 16'h0000, 16'h0000, 16'h0000);
        tick();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre_valid: got %b want 1", wb_valid); end
        drive_op(1'b1, 1'b1, 3'd3, WB_ALU, 1'b0, 16'h0066, 16'h0000, 16'h0000, 16'h0000);
        flush = 1'b1;
        tick();
        idle_inputs();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %b want 0", wb_valid); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL flush_write: got %b want 0", write); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL flush_err: got %b want 0", err); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd4, WB_ALU, 1'b0, 16'h0044, 16'h0000, 16'h0000, 16'h0000);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        idle_inputs();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL fs_valid: got %b want 0", wb_valid); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL fs_write: got %b want 0", write); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL fs_err: got %b want 1", err); end
        drive_op(1'b1, 1'b1, 3'd1, WB_ALU, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle_inputs();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL fs_resume_valid: got %b want 1", wb_valid); end
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL fs_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_halt_regwrite_err();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd1, WB_ALU, 1'b1, 16'h0009, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle_inputs();
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL hrw_err: got %b want 1", err); end
        tick();
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL hrw_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_halt();
        do_reset();
        drive_op(1'b1, 1'b0, 3'd0, WB_ALU, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        drive_op(1'b1, 1'b1, 3'd2, WB_ALU, 1'b0, 16'h0077, 16'h0000, 16'h0000, 16'h0000);
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_pre: got %b want 0", halted); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL halt_pre_write: got %b want 0", write); end
        tick();
        idle_inputs();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_set: got %b want 1", halted); end
        checks++; if (retire_cnt !== 16'd1) begin failures++; $display("[TB] FAIL halt_cnt: got %0d want 1", retire_cnt); end
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL halt_no_r2_write: got %b want 0", write); end
        tick();
        checks++; if (retire_cnt !== 16'd1) begin failures++; $display("[TB] FAIL halt_cnt_frozen: got %0d want 1", retire_cnt); end
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_sticky: got %b want 1", halted); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive_op(1'b1, 1'b0, 3'd0, WB_ALU, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (65535) @(posedge clk);
        #1;
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_preload: got %h want ffff", retire_cnt); end
        drive_op(1'b1, 1'b0, 3'd0, WB_ALU, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_zero: got %h want 0000", retire_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_op(1'b1, 1'b1, 3'd6, WB_IMM, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5);
        tick();
        idle_inputs();
        checks++; if (write !== 1'b1) begin failures++; $display("[TB] FAIL ar_pre_write: got %b want 1", write); end
        checks++; if (writedata !== 16'hA5A5) begin failures++; $display("[TB] FAIL ar_pre_data: got %h want a5a5", writedata); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL ar_write: got %b want 0", write); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL ar_valid: got %b want 0", wb_valid); end
        checks++; if (target_WB !== 3'd0) begin failures++; $display("[TB] FAIL ar_target: got %0d want 0", target_WB); end
        checks++; if (writedata !== 16'h0000) begin failures++; $display("[TB] FAIL ar_data: got %h want 0000", writedata); end
        checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL ar_cnt: got %0d want 0", retire_cnt); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL ar_release_write: got %b want 0", write); end
        checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL ar_release_cnt: got %0d want 0", retire_cnt); end
        drive_op(1'b1, 1'b1, 3'd7, WB_ALU, 1'b0, 16'h0BAD, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle_inputs();
        checks++; if (write !== 1'b1) begin failures++; $display("[TB] FAIL ar_resume_write: got %b want 1", write); end
        checks++; if (target_WB !== 3'd7) begin failures++; $display("[TB] FAIL ar_resume_target: got %0d want 7", target_WB); end
        checks++; if (writedata !== 16'h0BAD) begin failures++; $display("[TB] FAIL ar_resume_data: got %h want 0bad", writedata); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_load_capture();
        test_back_to_back();
        test_stall();
        test_flush();
        test_flush_stall();
        test_halt_regwrite_err();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
